mvp_serial: RTL and testbench

MVP_SERIAL -- requirements
Module: mvp_serial

---
 rtl/mvp_pkg.sv | 26 ++
 rtl/mvp_lane.sv | 76 +++++++
 rtl/mvp_serial.sv | 151 +++++++++++++++
 tb/tb_mvp_serial.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvp_pkg.sv
// Shared types and width helpers for the bit-serial matrix-vector product.
package mvp_pkg;

    // Controller states: waiting for a first plane, planes in flight, result on offer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Index width for N lanes / vector elements.
    function automatic int calc_a(input int n);
        return $clog2(n);
    endfunction

    // Signed width of one plane partial, which spans [-N, N].
    function automatic int calc_pw(input int n);
        return calc_a(n) + 2;
    endfunction

    // Signed accumulator width that cannot overflow for pmax planes.
    function automatic int calc_accw(input int n, input int pmax);
        return calc_a(n) + pmax + 1;
    endfunction

endpackage

// File: rtl/mvp_lane.sv
// One matrix row: signed +/-1 popcount of the current data plane against the
// row's weights, folded MSB-first into a shift-and-add accumulator.
module mvp_lane #(
    parameter int N    = 64,
    parameter int PW   = 8,
    parameter int ACCW = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           w_row,
    input  logic [N-1:0]           d_plane,
    input  logic                   load,
    input  logic                   first,
    input  logic                   neg,
    output logic signed [ACCW-1:0] acc
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0]          pos_cnt_s;
    logic [PW-1:0]          neg_cnt_s;
    logic signed [PW-1:0]   p_s;
    logic signed [ACCW-1:0] p_ext_s;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    // Partial: active elements count +1 where the weight is 1, -1 where it is 0.
    always_comb begin
        pos_cnt_s = '0;
        neg_cnt_s = '0;
        for (int j = 0; j < N; j++) begin
            if (d_plane[j]) begin
                if (w_row[j]) begin
                    pos_cnt_s = pos_cnt_s + ONE;
                end else begin
                    neg_cnt_s = neg_cnt_s + ONE;
                end
            end else begin
                pos_cnt_s = pos_cnt_s;
            end
        end
        p_s     = $signed(pos_cnt_s - neg_cnt_s);
        p_ext_s = ACCW'(p_s);
    end

    // Accumulator update: the first plane seeds (negated for a signed MSB),
    // later planes double the running value and add the new partial.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            if (first) begin
                if (neg) begin
                    acc_d = -p_ext_s;
                end else begin
                    acc_d = p_ext_s;
                end
            end else begin
                acc_d = (acc_q <<< 1) + p_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mvp_serial.sv
// Bit-serial +/-1 weight matrix times integer vector. Data arrives one bit-plane
// per beat, MSB first; each of the N lanes accumulates one row's dot product.
module mvp_serial
    import mvp_pkg::*;
#(
    parameter int  N    = 64,
    parameter int  PMAX = 8,
    localparam int ACCW = calc_accw(N, PMAX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N*N-1:0]      s_w,
    input  logic [N-1:0]        s_d,
    input  logic                s_last,
    input  logic                s_signed,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N*ACCW-1:0]   m_s,
    output logic                err
);

    localparam int            PW       = calc_pw(N);
    localparam int            CW       = $clog2(PMAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(PMAX - 1);

    state_e        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          sign_d, sign_q;
    logic          err_d, err_q;

    logic          accept_s;
    logic          first_s;
    logic          forced_s;
    logic          last_eff_s;
    logic          neg_s;

    // Handshake and beat classification; the PMAX-th beat always closes the product.
    always_comb begin
        accept_s   = s_valid && (state_q != HOLD);
        first_s    = (state_q == IDLE);
        forced_s   = (cnt_q == LAST_IDX);
        last_eff_s = s_last || forced_s;
        if (first_s) begin
            neg_s = s_signed;
        end else begin
            neg_s = sign_q;
        end
    end

    // Next-state, plane counter, sign capture and overrun flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sign_d = s_signed;
                    cnt_d  = CNT_ONE;
                    if (last_eff_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                    if (forced_s && !s_last) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_eff_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                    if (forced_s && !s_last) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
        end
    end

    assign s_ready = (state_q != HOLD);
    assign m_valid = (state_q == HOLD);
    assign err     = err_q;

    // One lane per matrix row; the result vector is the concatenated accumulators.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [ACCW-1:0] acc_s;

        mvp_lane #(
            .N    (N),
            .PW   (PW),
            .ACCW (ACCW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .w_row   (s_w[i*N +: N]),
            .d_plane (s_d),
            .load    (accept_s),
            .first   (first_s),
            .neg     (neg_s),
            .acc     (acc_s)
        );

        assign m_s[i*ACCW +: ACCW] = acc_s;
    end

endmodule

// File: tb/tb_mvp_serial.sv
// Directed self-checking bench for mvp_serial at N=8, PMAX=4 (ACCW=8).
module tb_mvp_serial;

    localparam int N    = 8;
    localparam int PMAX = 4;
    localparam int ACCW = 8;

    logic                clk;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic [N*N-1:0]      s_w;
    logic [N-1:0]        s_d;
    logic                s_last;
    logic                s_signed;
    logic                m_valid;
    logic                m_ready;
    logic [N*ACCW-1:0]   m_s;
    logic                err;

    int checks = 0;
    int errors = 0;

    mvp_serial #(.N(N), .PMAX(PMAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_w      (s_w),
        .s_d      (s_d),
        .s_last   (s_last),
        .s_signed (s_signed),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_s      (m_s),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one beat at the falling edge; it is accepted on the next rising edge.
    task automatic beat(input logic [N*N-1:0] w, input logic [N-1:0] d,
                        input logic last, input logic sgn);
        @(negedge clk);
        s_valid  = 1'b1;
        s_w      = w;
        s_d      = d;
        s_last   = last;
        s_signed = sgn;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_ready: s_ready=%b expected 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Complete the output handshake and confirm the result is withdrawn.
    task automatic consume();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume: m_valid=%b expected 0", m_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0 || m_s !== '0) begin
            errors++;
            $display("FAIL reset: m_valid=%b s_ready=%b err=%b m_s=%h expected 0 1 0 0",
                     m_valid, s_ready, err, m_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_beat(input logic sgn, input logic [ACCW-1:0] exp);
        beat('1, 8'hFF, 1'b0, sgn);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_beat_mid sgn=%b: m_valid=%b expected 0", sgn, m_valid);
        end
        beat('1, 8'hFF, 1'b1, sgn);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL two_beat_latency sgn=%b: m_valid=%b expected 1", sgn, m_valid);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (m_s[i*ACCW +: ACCW] !== exp) begin
                errors++;
                $display("FAIL two_beat_lane%0d sgn=%b: got %h expected %h",
                         i, sgn, m_s[i*ACCW +: ACCW], exp);
            end
        end
        consume();
    endtask

    task automatic test_single_beat(input logic [N-1:0] d, input logic [ACCW-1:0] exp);
        beat('0, d, 1'b1, 1'b0);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid d=%h: m_valid=%b expected 1", d, m_valid);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (m_s[i*ACCW +: ACCW] !== exp) begin
                errors++;
                $display("FAIL single_lane%0d d=%h: got %h expected %h",
                         i, d, m_s[i*ACCW +: ACCW], exp);
            end
        end
        consume();
    endtask

    task automatic test_overrun();
        for (int b = 0; b < 3; b++) begin
            beat('1, 8'hFF, 1'b0, 1'b0);
        end
        checks++;
        if (m_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: m_valid=%b err=%b expected 0 0", m_valid, err);
        end
        beat('1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL overrun_forced: m_valid=%b err=%b expected 1 1", m_valid, err);
        end
        // 8, 24, 56, 120 across four all-ones planes.
        @(negedge clk);
        s_valid = 1'b1;
        s_w     = '1;
        s_d     = 8'h0F;
        s_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_s !== {N{8'h78}}) begin
                errors++;
                $display("FAIL hold_stall c=%0d: s_ready=%b m_valid=%b m_s=%h expected 0 1 %h",
                         c, s_ready, m_valid, m_s, {N{8'h78}});
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_bypass: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_s !== {N{8'h04}} || err !== 1'b1) begin
            errors++;
            $display("FAIL after_stall: m_valid=%b m_s=%h err=%b expected 1 %h 1",
                     m_valid, m_s, err, {N{8'h04}});
        end
        consume();
    endtask

    task automatic test_reset_mid_and_gap();
        logic [N*N-1:0] w;
        int             e;
        beat('1, 8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_s !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: m_valid=%b s_ready=%b m_s=%h err=%b expected 0 1 0 0",
                     m_valid, s_ready, m_s, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Row i has its low i weights at +1: per-plane partial with d=FF is 2i-8.
        w = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < i; k++) begin
                w[i*N + k] = 1'b1;
            end
        end
        beat(w, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap: m_valid=%b s_ready=%b expected 0 1", m_valid, s_ready);
        end
        beat(w, 8'hFF, 1'b1, 1'b0);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_valid: m_valid=%b expected 1", m_valid);
        end
        for (int i = 0; i < N; i++) begin
            e = 3 * (2 * i - 8);
            checks++;
            if (m_s[i*ACCW +: ACCW] !== 8'(e)) begin
                errors++;
                $display("FAIL gap_lane%0d: got %h expected %h", i, m_s[i*ACCW +: ACCW], 8'(e));
            end
        end
        consume();
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_w      = '0;
        s_d      = '0;
        s_last   = 1'b0;
        s_signed = 1'b0;
        m_ready  = 1'b0;
        test_reset();
        test_two_beat(1'b0, 8'd24);
        test_two_beat(1'b1, 8'hF8);
        test_single_beat(8'hFF, 8'hF8);
        test_single_beat(8'h00, 8'h00);
        test_overrun();
        test_reset_mid_and_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
